// File: rtl/debounce_multi.sv
// debounce_multi: N independent button/switch debouncers. Each channel has a
// two-flop synchroniser, a stability counter, press/release pulses and
// long-press detection. Sticky press flags feed a combined interrupt.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] evt_pending,
    output logic            irq
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    // Last count value before the debounced level is allowed to flip.
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic          x;
            logic          s1_reg;
            logic          s2_reg;
            logic [SW-1:0] cnt_reg;
            logic [SW-1:0] cnt_next;
            logic          level_reg;
            logic          level_next;
            logic          rise_reg;
            logic          fall_reg;
            logic          evt_reg;

            assign x = btn_in[gi] ^ ACTIVE_LOW;

            // Stability counter: any return to the current level restarts the count.
            always_comb begin
                cnt_next   = cnt_reg;
                level_next = level_reg;
                if (s2_reg == level_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    level_next = s2_reg;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + SW'(1);
                end
            end

            // Synchroniser, debounced level, edge pulses and sticky press flag.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    evt_reg   <= 1'b0;
                end else begin
                    s1_reg    <= x;
                    s2_reg    <= s1_reg;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    rise_reg  <= level_next & ~level_reg;
                    fall_reg  <= ~level_next & level_reg;
                    // A press in the same cycle as a clear keeps the flag set.
                    evt_reg   <= rise_reg | (evt_reg & ~evt_clr[gi]);
                end
            end

            assign btn_out[gi]     = level_reg;
            assign rise_pulse[gi]  = rise_reg;
            assign fall_pulse[gi]  = fall_reg;
            assign evt_pending[gi] = evt_reg;

            if (LONG_CYCLES > 0) begin : g_long
                localparam int LW = $clog2(LONG_CYCLES + 1);
                localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
                localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
                logic [LW-1:0] hold_reg;
                logic          long_reg;

                // Hold counter tracks the upcoming level so that it equals the
                // number of pressed cycles so far; saturation makes the pulse one-shot.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        hold_reg <= '0;
                        long_reg <= 1'b0;
                    end else begin
                        if (!level_next) begin
                            hold_reg <= '0;
                        end else if (hold_reg != LONG_MAX) begin
                            hold_reg <= hold_reg + LW'(1);
                        end
                        long_reg <= level_next && (hold_reg == LONG_LAST);
                    end
                end

                assign long_pulse[gi] = long_reg;
            end else begin : g_nolong
                assign long_pulse[gi] = 1'b0;
            end
        end
    endgenerate

    // Interrupt is the registered OR of all pending press flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt_pending;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed test of debounce_multi (2 channels, short
// counters) plus an active-low instance, with hand-computed expectations.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] btn_in;
    logic [1:0] evt_clr;
    logic [1:0] btn_out, rise_pulse, fall_pulse, long_pulse, evt_pending;
    logic       irq;

    logic [1:0] btn_al;
    logic [1:0] al_evt_clr = 2'b00;
    logic [1:0] al_btn_out, al_rise, al_fall, al_long, al_evt;
    logic       al_irq;

    int checks = 0;
    int errors = 0;
    int rise_cnt [2] = '{0, 0};
    int fall_cnt [2] = '{0, 0};
    int long_cnt [2] = '{0, 0};
    int base;

    always #5 clk = ~clk;

    debounce_multi #(.N_CH(2), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .evt_clr(evt_clr),
        .btn_out(btn_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .long_pulse(long_pulse), .evt_pending(evt_pending), .irq(irq)
    );

    debounce_multi #(.N_CH(2), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_al), .evt_clr(al_evt_clr),
        .btn_out(al_btn_out), .rise_pulse(al_rise), .fall_pulse(al_fall),
        .long_pulse(al_long), .evt_pending(al_evt), .irq(al_irq)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rise_pulse[c]) rise_cnt[c]++;
            if (fall_pulse[c]) fall_cnt[c]++;
            if (long_pulse[c]) long_cnt[c]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        btn_in  = 2'b11;
        btn_al  = 2'b11;
        evt_clr = 2'b00;
        ticks(3);
        check("rst_btn",  32'(btn_out), 0);
        check("rst_rise", 32'(rise_pulse), 0);
        check("rst_fall", 32'(fall_pulse), 0);
        check("rst_long", 32'(long_pulse), 0);
        check("rst_evt",  32'(evt_pending), 0);
        check("rst_irq",  32'(irq), 0);
        check("rst_al",   32'(al_btn_out), 0);

        // Release reset with both buttons held: level flips 5 edges after first sample.
        reset_n = 1'b1;
        ticks(5);
        check("rel_early", 32'(btn_out), 0);
        tick();
        check("rel_btn",  32'(btn_out), 3);
        check("rel_rise", 32'(rise_pulse), 3);
        check("al_idle",  32'(al_btn_out), 0);
        tick();
        check("rel_rise_end", 32'(rise_pulse), 0);
        check("rel_evt", 32'(evt_pending), 3);
        check("rel_irq_lag", 32'(irq), 0);
        tick();
        check("rel_irq", 32'(irq), 1);
        btn_in = 2'b00;
        ticks(5);
        check("rel_hold", 32'(btn_out), 3);
        tick();
        check("rel_fall_btn", 32'(btn_out), 0);
        check("rel_fall", 32'(fall_pulse), 3);
        tick();
        check("rel_fall_end", 32'(fall_pulse), 0);
        evt_clr = 2'b11;
        tick();
        evt_clr = 2'b00;
        check("clr_evt", 32'(evt_pending), 0);
        check("clr_irq_lag", 32'(irq), 1);
        tick();
        check("clr_irq", 32'(irq), 0);
        check("short_no_long0", 32'(long_cnt[0]), 0);
        check("short_no_long1", 32'(long_cnt[1]), 0);

        // Clean press and release on ch0.
        base = rise_cnt[1];
        btn_in = 2'b01;
        ticks(5);
        check("cp_early", 32'(btn_out), 0);
        tick();
        check("cp_btn",  32'(btn_out), 1);
        check("cp_rise", 32'(rise_pulse), 1);
        tick();
        check("cp_rise_end", 32'(rise_pulse), 0);
        btn_in = 2'b00;
        ticks(5);
        check("cp_hold", 32'(btn_out), 1);
        tick();
        check("cp_rel",  32'(btn_out), 0);
        check("cp_fall", 32'(fall_pulse), 1);
        tick();
        check("cp_fall_end", 32'(fall_pulse), 0);
        check("cp_ch1_quiet", 32'(rise_cnt[1] - base), 0);

        // Bounce: high 3, low 1, high 6.
        base = rise_cnt[0];
        btn_in = 2'b01;
        ticks(3);
        btn_in = 2'b00;
        tick();
        btn_in = 2'b01;
        ticks(5);
        check("bn_early", 32'(btn_out), 0);
        tick();
        check("bn_btn",  32'(btn_out), 1);
        check("bn_rise", 32'(rise_pulse), 1);
        btn_in = 2'b00;
        ticks(8);
        check("bn_one_rise", 32'(rise_cnt[0] - base), 1);

        // Glitches of 1..3 cycles never move the level.
        base = rise_cnt[0];
        for (int w = 1; w <= 3; w++) begin
            btn_in = 2'b01;
            ticks(w);
            btn_in = 2'b00;
            ticks(8);
        end
        check("glitch_btn",  32'(btn_out), 0);
        check("glitch_rise", 32'(rise_cnt[0] - base), 0);

        // Event flags and interrupt.
        evt_clr = 2'b01;
        tick();
        evt_clr = 2'b00;
        check("ev_pre_clr", 32'(evt_pending), 0);
        tick();
        check("ev_pre_irq", 32'(irq), 0);
        btn_in = 2'b01;
        ticks(6);
        check("ev_rise", 32'(rise_pulse), 1);
        check("ev_not_yet", 32'(evt_pending), 0);
        tick();
        check("ev_set", 32'(evt_pending), 1);
        check("ev_irq_lag", 32'(irq), 0);
        tick();
        check("ev_irq", 32'(irq), 1);
        evt_clr = 2'b01;
        tick();
        evt_clr = 2'b00;
        check("ev_clr", 32'(evt_pending), 0);
        check("ev_clr_irq_lag", 32'(irq), 1);
        tick();
        check("ev_clr_irq", 32'(irq), 0);
        btn_in = 2'b00;
        ticks(8);
        btn_in = 2'b01;
        ticks(6);
        check("ev_rise2", 32'(rise_pulse), 1);
        evt_clr = 2'b01;
        tick();
        evt_clr = 2'b00;
        check("ev_set_wins", 32'(evt_pending), 1);
        btn_in = 2'b00;
        ticks(8);
        evt_clr = 2'b01;
        tick();
        evt_clr = 2'b00;

        // Long press on ch1.
        base = long_cnt[1];
        btn_in = 2'b10;
        ticks(6);
        check("lp_btn", 32'(btn_out), 2);
        ticks(8);
        check("lp_cycle9", 32'(long_pulse), 0);
        tick();
        check("lp_cycle10", 32'(long_pulse), 2);
        tick();
        check("lp_end", 32'(long_pulse), 0);
        ticks(20);
        check("lp_once", 32'(long_cnt[1] - base), 1);
        btn_in = 2'b00;
        ticks(8);
        btn_in = 2'b10;
        ticks(15);
        check("lp_again", 32'(long_pulse), 2);
        btn_in = 2'b00;
        ticks(8);
        base = long_cnt[1];
        btn_in = 2'b10;
        ticks(6);
        check("lp9_btn", 32'(btn_out), 2);
        ticks(3);
        btn_in = 2'b00;
        ticks(5);
        check("lp9_hold", 32'(btn_out), 2);
        tick();
        check("lp9_fall", 32'(fall_pulse), 2);
        ticks(5);
        check("lp9_none", 32'(long_cnt[1] - base), 0);

        // Active-low instance: drive ch0 low.
        btn_al = 2'b10;
        ticks(5);
        check("al_early", 32'(al_btn_out), 0);
        tick();
        check("al_btn",  32'(al_btn_out), 1);
        check("al_rise", 32'(al_rise), 1);
        btn_al = 2'b11;
        ticks(8);

        // Reset while counting: no level change, no pulse, debounce restarts.
        base = rise_cnt[0];
        btn_in = 2'b01;
        ticks(4);
        reset_n = 1'b0;
        #1;
        check("mr_btn", 32'(btn_out), 0);
        ticks(3);
        reset_n = 1'b1;
        ticks(5);
        check("mr_early", 32'(btn_out), 0);
        check("mr_no_pulse", 32'(rise_cnt[0] - base), 0);
        tick();
        check("mr_restart", 32'(btn_out), 1);
        // Reset while pressed: level clears with no release pulse.
        base = fall_cnt[0];
        ticks(2);
        reset_n = 1'b0;
        #1;
        check("mp_btn", 32'(btn_out), 0);
        ticks(3);
        check("mp_no_fall", 32'(fall_cnt[0] - base), 0);
        reset_n = 1'b1;
        btn_in  = 2'b00;
        ticks(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
